ex_oitf: RTL and testbench

Outstanding Instruction Track FIFO (OITF) for the long-pipe (LSU) path. Dispatch allocates one entry per issued long-pipe instruction and receives its itag. The long-pipe writeback arbiter retires entries strictly in order from the head, using ret_ptr and the head entry's rdidx/pc/rdwen/rdfpu. The block also reports whether dispatched source or destination registers collide with any outstanding write, so dispatch can stall on RAW/WAW hazards.

---
 rtl/ex_oitf.sv | 153 +++++++++++++++
 tb/tb_ex_oitf.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_oitf.sv
// Outstanding Instruction Track FIFO for the long-pipe (LSU) path.
// Dispatch allocates entries in order and receives each entry's itag.
// The writeback arbiter retires entries in order from the head.
// Combinational match flags report RAW/WAW collisions with outstanding integer writes.
module ex_oitf #(
  parameter int DEPTH   = 2,
  parameter int ITAG_W  = 1,
  parameter int RFIDX_W = 5,
  parameter int PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               dis_ena,
  output logic               dis_ready,
  output logic [ITAG_W-1:0]  dis_ptr,
  input  logic [RFIDX_W-1:0] dis_rdidx,
  input  logic               dis_rdwen,
  input  logic               dis_rdfpu,
  input  logic [PC_W-1:0]    dis_pc,

  input  logic               disp_rs1en,
  input  logic               disp_rs2en,
  input  logic               disp_rdwen,
  input  logic [RFIDX_W-1:0] disp_rs1idx,
  input  logic [RFIDX_W-1:0] disp_rs2idx,
  input  logic [RFIDX_W-1:0] disp_rdidx,
  output logic               oitfrd_match_disprs1,
  output logic               oitfrd_match_disprs2,
  output logic               oitfrd_match_disprd,

  input  logic               ret_ena,
  output logic [ITAG_W-1:0]  oitf_ret_ptr,
  output logic [RFIDX_W-1:0] oitf_ret_rdidx,
  output logic               oitf_ret_rdwen,
  output logic               oitf_ret_rdfpu,
  output logic [PC_W-1:0]    oitf_ret_pc,

  output logic               oitf_empty,
  output logic               oitf_full
);

  localparam logic [ITAG_W-1:0] LAST_IDX = ITAG_W'(DEPTH - 1);

  logic [ITAG_W-1:0]  r_alc_ptr;
  logic [ITAG_W-1:0]  r_ret_ptr;
  logic               r_alc_flg;
  logic               r_ret_flg;

  logic [DEPTH-1:0]   r_vld;
  logic [RFIDX_W-1:0] r_rdidx [DEPTH];
  logic               r_rdwen [DEPTH];
  logic               r_rdfpu [DEPTH];
  logic [PC_W-1:0]    r_pc    [DEPTH];

  logic w_ptr_eq;
  logic w_empty;
  logic w_full;
  logic w_alc_vld;
  logic w_ret_vld;
  logic w_hit_rs1;
  logic w_hit_rs2;
  logic w_hit_rd;

  // The wrap flags tell full from empty when both pointers coincide.
  assign w_ptr_eq  = (r_alc_ptr == r_ret_ptr);
  assign w_empty   = w_ptr_eq & (r_alc_flg == r_ret_flg);
  assign w_full    = w_ptr_eq & (r_alc_flg != r_ret_flg);
  // Neither side bypasses the other: a full FIFO refuses allocation even while retiring.
  assign w_alc_vld = dis_ena & ~w_full;
  assign w_ret_vld = ret_ena & ~w_empty;

  assign oitf_empty = w_empty;
  assign oitf_full  = w_full;
  assign dis_ready  = ~w_full;
  assign dis_ptr    = r_alc_ptr;

  assign oitf_ret_ptr   = r_ret_ptr;
  assign oitf_ret_rdidx = r_rdidx[r_ret_ptr];
  assign oitf_ret_rdwen = r_rdwen[r_ret_ptr];
  assign oitf_ret_rdfpu = r_rdfpu[r_ret_ptr];
  assign oitf_ret_pc    = r_pc[r_ret_ptr];

  // Advance the allocate and retire pointers, toggling the wrap flag on each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alc_ptr <= '0;
      r_ret_ptr <= '0;
      r_alc_flg <= 1'b0;
      r_ret_flg <= 1'b0;
    end else begin
      if (w_alc_vld) begin
        if (r_alc_ptr == LAST_IDX) begin
          r_alc_ptr <= '0;
          r_alc_flg <= ~r_alc_flg;
        end else begin
          r_alc_ptr <= r_alc_ptr + 1'b1;
        end
      end
      if (w_ret_vld) begin
        if (r_ret_ptr == LAST_IDX) begin
          r_ret_ptr <= '0;
          r_ret_flg <= ~r_ret_flg;
        end else begin
          r_ret_ptr <= r_ret_ptr + 1'b1;
        end
      end
    end
  end

  // Record the payload on allocate; a retire only clears the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rdidx[i] <= '0;
        r_rdwen[i] <= 1'b0;
        r_rdfpu[i] <= 1'b0;
        r_pc[i]    <= '0;
      end
    end else begin
      if (w_ret_vld) begin
        r_vld[r_ret_ptr] <= 1'b0;
      end
      if (w_alc_vld) begin
        r_vld[r_alc_ptr]   <= 1'b1;
        r_rdidx[r_alc_ptr] <= dis_rdidx;
        r_rdwen[r_alc_ptr] <= dis_rdwen;
        r_rdfpu[r_alc_ptr] <= dis_rdfpu;
        r_pc[r_alc_ptr]    <= dis_pc;
      end
    end
  end

  // Compare dispatch register indices against every outstanding integer-rd write.
  always_comb begin
    w_hit_rs1 = 1'b0;
    w_hit_rs2 = 1'b0;
    w_hit_rd  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && r_rdwen[i] && !r_rdfpu[i]) begin
        if (r_rdidx[i] == disp_rs1idx) w_hit_rs1 = 1'b1;
        if (r_rdidx[i] == disp_rs2idx) w_hit_rs2 = 1'b1;
        if (r_rdidx[i] == disp_rdidx)  w_hit_rd  = 1'b1;
      end
    end
  end

  assign oitfrd_match_disprs1 = disp_rs1en & w_hit_rs1;
  assign oitfrd_match_disprs2 = disp_rs2en & w_hit_rs2;
  assign oitfrd_match_disprd  = disp_rdwen & w_hit_rd;

endmodule

// File: tb/tb_ex_oitf.sv
// Self-checking bench for ex_oitf, using a queue-based reference model.
module tb_ex_oitf;
  localparam int DEPTH   = 2;
  localparam int ITAG_W  = 1;
  localparam int RFIDX_W = 5;
  localparam int PC_W    = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               dis_ena;
  logic               dis_ready;
  logic [ITAG_W-1:0]  dis_ptr;
  logic [RFIDX_W-1:0] dis_rdidx;
  logic               dis_rdwen;
  logic               dis_rdfpu;
  logic [PC_W-1:0]    dis_pc;
  logic               disp_rs1en, disp_rs2en, disp_rdwen;
  logic [RFIDX_W-1:0] disp_rs1idx, disp_rs2idx, disp_rdidx;
  logic               m_rs1, m_rs2, m_rd;
  logic               ret_ena;
  logic [ITAG_W-1:0]  ret_ptr;
  logic [RFIDX_W-1:0] ret_rdidx;
  logic               ret_rdwen, ret_rdfpu;
  logic [PC_W-1:0]    ret_pc;
  logic               empty, full;

  int n_tests = 0;
  int n_fail  = 0;

  ex_oitf #(.DEPTH(DEPTH), .ITAG_W(ITAG_W), .RFIDX_W(RFIDX_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
    .dis_rdidx(dis_rdidx), .dis_rdwen(dis_rdwen), .dis_rdfpu(dis_rdfpu), .dis_pc(dis_pc),
    .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en), .disp_rdwen(disp_rdwen),
    .disp_rs1idx(disp_rs1idx), .disp_rs2idx(disp_rs2idx), .disp_rdidx(disp_rdidx),
    .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2), .oitfrd_match_disprd(m_rd),
    .ret_ena(ret_ena), .oitf_ret_ptr(ret_ptr), .oitf_ret_rdidx(ret_rdidx),
    .oitf_ret_rdwen(ret_rdwen), .oitf_ret_rdfpu(ret_rdfpu), .oitf_ret_pc(ret_pc),
    .oitf_empty(empty), .oitf_full(full)
  );

  always #5 clk = ~clk;

  // Reference model: in-order list of outstanding instructions plus lifetime counts.
  typedef struct {
    logic [RFIDX_W-1:0] rd;
    logic               wen;
    logic               fpu;
    logic [PC_W-1:0]    pc;
  } ent_t;

  ent_t q[$];
  int   alc_cnt = 0;
  int   ret_cnt = 0;

  function automatic void model_step();
    bit a, r;
    if (rst) begin
      q.delete();
      alc_cnt = 0;
      ret_cnt = 0;
    end else begin
      a = dis_ena && (q.size() < DEPTH);
      r = ret_ena && (q.size() > 0);
      if (r) begin
        q.delete(0);
        ret_cnt++;
      end
      if (a) begin
        q.push_back('{dis_rdidx, dis_rdwen, dis_rdfpu, dis_pc});
        alc_cnt++;
      end
    end
  endfunction

  function automatic bit model_hit(input logic [RFIDX_W-1:0] idx);
    foreach (q[k]) if (q[k].wen && !q[k].fpu && q[k].rd == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    rst = 0; dis_ena = 0; ret_ena = 0;
    dis_rdidx = '0; dis_rdwen = 0; dis_rdfpu = 0; dis_pc = '0;
    disp_rs1en = 0; disp_rs2en = 0; disp_rdwen = 0;
    disp_rs1idx = '0; disp_rs2idx = '0; disp_rdidx = '0;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled one unit later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_req(input logic [RFIDX_W-1:0] rd, input logic wen, input logic fpu,
                           input logic [PC_W-1:0] pc);
    dis_ena = 1; dis_rdidx = rd; dis_rdwen = wen; dis_rdfpu = fpu; dis_pc = pc;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    disp_rs1en = 1; disp_rs2en = 1; disp_rdwen = 1;
    #1;
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_tests++; if (dis_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", dis_ready); end
    n_tests++; if (dis_ptr !== '0) begin n_fail++; $display("FAIL reset_dis_ptr got %0d want 0", dis_ptr); end
    n_tests++; if (ret_ptr !== '0) begin n_fail++; $display("FAIL reset_ret_ptr got %0d want 0", ret_ptr); end
    n_tests++; if (ret_pc !== '0 || ret_rdidx !== '0 || ret_rdwen !== 1'b0 || ret_rdfpu !== 1'b0) begin
      n_fail++; $display("FAIL reset_head got pc=%h rd=%0d wen=%b fpu=%b want all 0", ret_pc, ret_rdidx, ret_rdwen, ret_rdfpu);
    end
    n_tests++; if ({m_rs1, m_rs2, m_rd} !== 3'b000) begin n_fail++; $display("FAIL reset_match got %b want 000", {m_rs1, m_rs2, m_rd}); end
    idle_inputs();
  endtask

  task automatic test_fill_drain();
    do_reset();
    alloc_req(5, 1, 0, 32'h100); #1;
    n_tests++; if (dis_ptr !== 1'd0) begin n_fail++; $display("FAIL fill_ptr0 got %0d want 0", dis_ptr); end
    tick();
    alloc_req(7, 1, 0, 32'h104); #1;
    n_tests++; if (dis_ptr !== 1'd1) begin n_fail++; $display("FAIL fill_ptr1 got %0d want 1", dis_ptr); end
    tick();
    alloc_req(9, 1, 0, 32'h108); #1;
    n_tests++; if (full !== 1'b1 || dis_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got full=%b ready=%b want 1/0", full, dis_ready); end
    tick();
    dis_ena = 0; #1;
    n_tests++; if (full !== 1'b1 || ret_pc !== 32'h100 || dis_ptr !== 1'd0) begin
      n_fail++; $display("FAIL fill_blocked got full=%b pc=%h ptr=%0d want 1/100/0", full, ret_pc, dis_ptr);
    end
    ret_ena = 1; tick(); #1;
    n_tests++; if (ret_pc !== 32'h104 || ret_rdidx !== 5'd7) begin n_fail++; $display("FAIL drain_head got pc=%h rd=%0d want 104/7", ret_pc, ret_rdidx); end
    tick(); ret_ena = 0; #1;
    n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL drain_empty got empty=%b full=%b want 1/0", empty, full); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [ITAG_W-1:0] exp_tag;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_req(5'(i + 1), 1, 0, 32'h200 + 32'(4 * i)); #1;
      exp_tag = ITAG_W'(i % DEPTH);
      n_tests++; if (dis_ptr !== exp_tag) begin n_fail++; $display("FAIL wrap_tag[%0d] got %0d want %0d", i, dis_ptr, exp_tag); end
      tick();
      dis_ena = 0; ret_ena = 1; #1;
      n_tests++; if (ret_pc !== 32'h200 + 32'(4 * i) || empty !== 1'b0 || full !== 1'b0) begin
        n_fail++; $display("FAIL wrap_ret[%0d] got pc=%h empty=%b full=%b want %h/0/0", i, ret_pc, empty, full, 32'h200 + 32'(4 * i));
      end
      tick();
      ret_ena = 0; #1;
      n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty[%0d] got %b want 1", i, empty); end
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    do_reset();
    // empty: retire is ignored, allocation proceeds
    alloc_req(3, 1, 0, 32'h300); ret_ena = 1; tick();
    dis_ena = 0; ret_ena = 0; #1;
    n_tests++; if (empty !== 1'b0 || ret_pc !== 32'h300 || dis_ptr !== 1'd1 || ret_ptr !== 1'd0) begin
      n_fail++; $display("FAIL simul_empty got empty=%b pc=%h dptr=%0d rptr=%0d want 0/300/1/0", empty, ret_pc, dis_ptr, ret_ptr);
    end
    // one outstanding: occupancy stays at one, head advances
    alloc_req(4, 1, 0, 32'h304); ret_ena = 1; tick();
    dis_ena = 0; ret_ena = 0; #1;
    n_tests++; if (empty !== 1'b0 || full !== 1'b0 || ret_pc !== 32'h304 || ret_ptr !== 1'd1) begin
      n_fail++; $display("FAIL simul_one got empty=%b full=%b pc=%h rptr=%0d want 0/0/304/1", empty, full, ret_pc, ret_ptr);
    end
    alloc_req(6, 1, 0, 32'h308); tick();
    // full: no bypass, only the retire happens
    alloc_req(8, 1, 0, 32'h30c); ret_ena = 1; #1;
    n_tests++; if (dis_ready !== 1'b0) begin n_fail++; $display("FAIL simul_full_ready got %b want 0", dis_ready); end
    tick();
    dis_ena = 0; ret_ena = 0; #1;
    n_tests++; if (full !== 1'b0 || empty !== 1'b0 || ret_pc !== 32'h308 || dis_ptr !== 1'd1) begin
      n_fail++; $display("FAIL simul_full got full=%b empty=%b pc=%h dptr=%0d want 0/0/308/1", full, empty, ret_pc, dis_ptr);
    end
    ret_ena = 1; tick(); ret_ena = 0; #1;
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL simul_drain got %b want 1", empty); end
    idle_inputs();
  endtask

  task automatic test_hazard();
    do_reset();
    // an entry being allocated is not yet visible
    alloc_req(5, 1, 0, 32'h400);
    disp_rs1en = 1; disp_rs1idx = 5; disp_rs2en = 1; disp_rs2idx = 5; disp_rdwen = 1; disp_rdidx = 5; #1;
    n_tests++; if ({m_rs1, m_rs2, m_rd} !== 3'b000) begin n_fail++; $display("FAIL haz_alloc_invisible got %b want 000", {m_rs1, m_rs2, m_rd}); end
    tick();
    dis_ena = 0; #1;
    n_tests++; if ({m_rs1, m_rs2, m_rd} !== 3'b111) begin n_fail++; $display("FAIL haz_match got %b want 111", {m_rs1, m_rs2, m_rd}); end
    disp_rs1en = 0; disp_rs2idx = 6; #1;
    n_tests++; if ({m_rs1, m_rs2, m_rd} !== 3'b001) begin n_fail++; $display("FAIL haz_enable got %b want 001", {m_rs1, m_rs2, m_rd}); end
    // retiring entry still matches; replacement fp entry with rd=5
    disp_rs1en = 1; ret_ena = 1; alloc_req(5, 1, 1, 32'h404); #1;
    n_tests++; if (m_rs1 !== 1'b1) begin n_fail++; $display("FAIL haz_retiring got %b want 1", m_rs1); end
    tick();
    dis_ena = 0; ret_ena = 0; #1;
    n_tests++; if ({m_rs1, m_rd} !== 2'b00) begin n_fail++; $display("FAIL haz_fpu got %b want 00", {m_rs1, m_rd}); end
    ret_ena = 1; tick(); ret_ena = 0; #1;
    n_tests++; if ({m_rs1, m_rd} !== 2'b00 || empty !== 1'b1) begin n_fail++; $display("FAIL haz_retired got %b empty=%b want 00/1", {m_rs1, m_rd}, empty); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_req(3, 1, 0, 32'h500); tick();
    alloc_req(4, 1, 0, 32'h504); tick();
    alloc_req(9, 1, 0, 32'h508); rst = 1; ret_ena = 1; tick();
    rst = 0; dis_ena = 0; ret_ena = 0;
    disp_rs1en = 1; disp_rs1idx = 3; disp_rdwen = 1; disp_rdidx = 4; #1;
    n_tests++; if (empty !== 1'b1 || full !== 1'b0 || dis_ptr !== '0 || ret_ptr !== '0) begin
      n_fail++; $display("FAIL midrst_state got empty=%b full=%b dptr=%0d rptr=%0d want 1/0/0/0", empty, full, dis_ptr, ret_ptr);
    end
    n_tests++; if ({m_rs1, m_rd} !== 2'b00) begin n_fail++; $display("FAIL midrst_match got %b want 00", {m_rs1, m_rd}); end
    idle_inputs();
  endtask

  task automatic test_random();
    ent_t h;
    logic [ITAG_W-1:0] e_dptr, e_rptr;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 63) == 0);
      dis_ena    = $urandom_range(0, 1);
      ret_ena    = $urandom_range(0, 1);
      dis_rdidx  = 5'($urandom_range(0, 3));
      dis_rdwen  = $urandom_range(0, 3) != 0;
      dis_rdfpu  = $urandom_range(0, 3) == 0;
      dis_pc     = $urandom;
      disp_rs1en = $urandom_range(0, 1);  disp_rs1idx = 5'($urandom_range(0, 3));
      disp_rs2en = $urandom_range(0, 1);  disp_rs2idx = 5'($urandom_range(0, 3));
      disp_rdwen = $urandom_range(0, 1);  disp_rdidx  = 5'($urandom_range(0, 3));
      #1;
      e_dptr = ITAG_W'(alc_cnt % DEPTH);
      e_rptr = ITAG_W'(ret_cnt % DEPTH);
      n_tests++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH) || dis_ready !== (q.size() != DEPTH)) begin
        n_fail++; $display("FAIL rnd_flags[%0d] got e=%b f=%b r=%b occupancy=%0d", c, empty, full, dis_ready, q.size());
      end
      n_tests++; if (dis_ptr !== e_dptr || ret_ptr !== e_rptr) begin
        n_fail++; $display("FAIL rnd_ptrs[%0d] got %0d/%0d want %0d/%0d", c, dis_ptr, ret_ptr, e_dptr, e_rptr);
      end
      n_tests++; if (m_rs1 !== (disp_rs1en && model_hit(disp_rs1idx)) || m_rs2 !== (disp_rs2en && model_hit(disp_rs2idx))
                     || m_rd !== (disp_rdwen && model_hit(disp_rdidx))) begin
        n_fail++; $display("FAIL rnd_match[%0d] got %b%b%b", c, m_rs1, m_rs2, m_rd);
      end
      if (q.size() > 0) begin
        h = q[0];
        n_tests++; if (ret_pc !== h.pc || ret_rdidx !== h.rd || ret_rdwen !== h.wen || ret_rdfpu !== h.fpu) begin
          n_fail++; $display("FAIL rnd_head[%0d] got %h/%0d/%b/%b want %h/%0d/%b/%b", c, ret_pc, ret_rdidx, ret_rdwen, ret_rdfpu, h.pc, h.rd, h.wen, h.fpu);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
